// File: rtl/qdiv_pkg.sv
// Shared constants for the sequential fixed-point divider: FSM state encodings,
// saturation limits at the default width, and the bit-counter width helper.
package qdiv_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Saturation limits at the default word width (N = 32).
  localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] QMIN = 32'h8000_0000;

  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned q);
    return $clog2(n + q);
  endfunction

endpackage

// File: rtl/qdiv_seq_if.sv
// Operand/result handshake bundle for qdiv_seq. Signal names keep the
// divider's own i_/o_ view; master drives operands and consumes results.
interface qdiv_seq_if
  import qdiv_pkg::*;
#(
  parameter int unsigned N = 32
);

  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_quotient;
  logic         o_ovr;
  logic         o_dz;

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_ovr, o_dz
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_ovr, o_dz
  );

endinterface

// File: rtl/qdiv_sat.sv
// Converts the raw (N+Q)-bit magnitude quotient plus sign into a signed (N,Q)
// result, saturating on overflow and forcing the limit value on divide by zero.
module qdiv_sat
  import qdiv_pkg::*;
#(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic [N+Q-1:0] mag,
  input  logic           sign,
  input  logic           dz,
  output logic [N-1:0]   quotient,
  output logic           ovr,
  output logic           dz_out
);

  localparam logic [N-1:0] QMaxN = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] QMinN = {1'b1, {(N-1){1'b0}}};

  logic hi_nz;
  logic pos_ovr;
  logic neg_ovr;

  assign hi_nz   = |mag[N+Q-1:N];
  // Positive limit is 2^(N-1)-1; negative side may reach exactly 2^(N-1).
  assign pos_ovr = hi_nz | mag[N-1];
  assign neg_ovr = hi_nz | (mag[N-1] & (|mag[N-2:0]));

  always_comb begin
    quotient = mag[N-1:0];
    ovr      = 1'b0;
    dz_out   = dz;
    if (dz) begin
      quotient = sign ? QMinN : QMaxN;
    end else if (sign) begin
      if (neg_ovr) begin
        quotient = QMinN;
        ovr      = 1'b1;
      end else begin
        quotient = ~mag[N-1:0] + 1'b1;
      end
    end else if (pos_ovr) begin
      quotient = QMaxN;
      ovr      = 1'b1;
    end
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed (N,Q) divider: restoring long division of |dividend|<<Q by
// |divisor|, one quotient bit per clock, with saturation and divide-by-zero flag.
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  qdiv_seq_if.slave bus
);

  localparam int unsigned CntW = cnt_width(N, Q);
  localparam int unsigned W    = N + Q;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      rem_q, rem_d;
  // Holds the shifted dividend; quotient bits enter at the LSB as dividend bits leave.
  logic [W-1:0]    work_q, work_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic            sign_q, sign_d;
  logic            dz_q, dz_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    quot_q, quot_d;
  logic            ovr_q, ovr_d;
  logic            dzo_q, dzo_d;

  logic [N-1:0]    abs_dvd;
  logic [N-1:0]    abs_dvs;
  logic [N+1:0]    rem_sh;
  logic [N+1:0]    rem_diff;
  logic            q_bit;

  logic [N-1:0]    sat_quot;
  logic            sat_ovr;
  logic            sat_dz;

  assign abs_dvd = bus.i_dividend[N-1] ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
  assign abs_dvs = bus.i_divisor[N-1]  ? (~bus.i_divisor + 1'b1)  : bus.i_divisor;

  assign rem_sh   = {rem_q, work_q[W-1]};
  assign rem_diff = rem_sh - {2'b00, dvs_q};
  assign q_bit    = (rem_sh >= {2'b00, dvs_q});

  qdiv_sat #(
    .Q (Q),
    .N (N)
  ) u_sat (
    .mag      (work_q),
    .sign     (sign_q),
    .dz       (dz_q),
    .quotient (sat_quot),
    .ovr      (sat_ovr),
    .dz_out   (sat_dz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    valid_d = valid_q;
    quot_d  = quot_q;
    ovr_d   = ovr_q;
    dzo_d   = dzo_q;
    case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          work_d  = {abs_dvd, {Q{1'b0}}};
          dvs_d   = abs_dvs;
          // A zero divisor has a clear sign bit, so this is the dividend sign for dz.
          sign_d  = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
          dz_d    = (bus.i_divisor == '0);
          rem_d   = '0;
          cnt_d   = CntW'(W - 1);
          state_d = (bus.i_divisor == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        rem_d  = q_bit ? rem_diff[N:0] : rem_sh[N:0];
        work_d = {work_q[W-2:0], q_bit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // First DONE cycle registers the saturated result; then wait for consume.
        if (!valid_q) begin
          valid_d = 1'b1;
          quot_d  = sat_quot;
          ovr_d   = sat_ovr;
          dzo_d   = sat_dz;
        end else if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      ovr_q   <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      ovr_q   <= ovr_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.o_ready    = (state_q == StIdle);
  assign bus.o_valid    = valid_q;
  assign bus.o_quotient = quot_q;
  assign bus.o_ovr      = ovr_q;
  assign bus.o_dz       = dzo_q;

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Sequential signed fixed-point divider for the convolver datapath; it is the inverse companion of the fixed-point multiplier.
- Computes o_quotient = (i_dividend << Q) / i_divisor. Operands and result are all signed (N,Q) two's-complement.
- The result is returned as N bits with the binary point unchanged, so the same Q format carries through the pipeline.
- Normalisation stages use it to divide by window size or scale. It trades one quotient bit per clock for minimal area.

Parameters:
- Q, 15, number of fractional bits in operands and result.
- N, 32, total word width in bits (sign included).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  divider idle, can accept operands.
- i_dividend  input  N  signed (N,Q) dividend.
- i_divisor  input  N  signed (N,Q) divisor.
- o_valid  output  1  result valid, held until consumed.
- i_ready  input  1  downstream accepts result.
- o_quotient  output  N  signed (N,Q) quotient.
- o_ovr  output  1  result saturated (magnitude overflow); qualified by o_valid.
- o_dz  output  1  divide by zero; qualified by o_valid.

Behaviour:
- Interface decided: one clock i_clk; reset i_rst_n is synchronous and active-low.
- Reset (i_rst_n=0 sampled at an edge): state IDLE, o_ready=1, o_valid=0, o_quotient=0, o_ovr=0, o_dz=0. Internal counter and remainder are cleared.
- Reset mid-operation aborts the operation. The in-flight result is discarded and no o_valid is produced.
- States:
  - IDLE: o_ready=1. The accept handshake is i_valid&o_ready at an edge. On accept:
    - latch sign = dividend_sign XOR divisor_sign;
    - latch N-bit magnitudes |dividend| and |divisor| (|-2^(N-1)| = 2^(N-1) is representable unsigned);
    - latch dz = (divisor==0);
    - go to CALC, or go directly to DONE if dz.
  - CALC: restoring long division of the (N+Q)-bit value |dividend|<<Q by |divisor|.
    - One quotient bit per cycle, MSB first; counter runs N+Q-1 down to 0.
    - Remainder register is N+1 bits.
    - After the final bit, go to DONE.
  - DONE: o_valid=1; o_quotient, o_ovr and o_dz are stable. When i_valid... no — when o_valid&i_ready at an edge, go to IDLE.
- o_ready=0 in CALC and DONE. A new operand cannot be accepted in the same cycle a result is consumed; the divider returns to IDLE first.
- Latency:
  - Normal case: o_valid rises N+Q+1 edges after the accept edge (48 cycles at defaults).
  - dz case: o_valid rises on the edge following accept.
- Rounding: truncation toward zero (magnitude truncated, then sign applied).
- Saturation:
  - Overflow when the raw (N+Q)-bit magnitude quotient exceeds 2^(N-1)-1 for a positive result, or 2^(N-1) for a negative result.
  - On overflow: o_quotient = 0x7FF..F (positive) or 0x800..0 (negative), o_ovr=1.
- Divide by zero: o_dz=1, o_ovr=0.
  - o_quotient = 0x7FF..F if dividend >= 0, else 0x800..0.
  - A zero dividend with a zero divisor yields 0x7FF..F.
- Zero quotient with a negative sign gives 0 (no negative zero).
- Backpressure: i_ready may stay low indefinitely; outputs hold their values.
- Input ports are not sampled outside the accept handshake.

Decomposition:
- Shared package qdiv_pkg holds:
  - state enumeration (IDLE, CALC, DONE);
  - constants QMAX = 2^(N-1)-1 and QMIN = -2^(N-1);
  - counter width clog2(N+Q).
- One natural sub-module: qdiv_sat, a combinational block that takes the raw magnitude, sign and dz, and produces o_quotient, o_ovr and o_dz. It is instantiated once, feeding the DONE output registers.

Test Plan (defaults Q=15, N=32):
- 1.5/0.5: i_dividend 0x0000C000, i_divisor 0x00004000 -> o_quotient 0x00018000, o_ovr=0, o_dz=0. o_valid exactly 48 edges after the accept edge.
- Sign and truncation:
  - -1.0/4.0: 0xFFFF8000 / 0x00020000 -> 0xFFFFE000.
  - 1/3: 0x00008000 / 0x00018000 -> 0x00002AAA.
  - -1/3 -> 0xFFFFD556.
- Overflow: 0x7FFFFFFF / 0x00000001 -> 0x7FFFFFFF, o_ovr=1.
- Overflow: 0x80000000 / 0x00000001 -> 0x80000000, o_ovr=1.
- Divide by zero: 0xFFFF0000 / 0 -> 0x80000000, o_dz=1, o_valid on the next edge. 0 / 0 -> 0x7FFFFFFF, o_dz=1.
- Handshake:
  - hold i_ready=0 for 10 cycles in DONE -> outputs stable and o_ready=0 throughout;
  - i_valid asserted during CALC -> ignored;
  - back-to-back ops -> second accept occurs at the earliest one cycle after consume.
- Reset mid-CALC:
  - assert i_rst_n=0 at cycle 20 of CALC -> o_valid never asserts; next edge shows o_ready=1 and all outputs 0;
  - a fresh 1.5/0.5 then yields 0x00018000.
